// File: rtl/blit_pkg.sv
// blit_pkg: shared constants, FSM states and pipeline types for the sprite blitter.
package blit_pkg;
  localparam int AW = 19;
  localparam int FB_W = 240;
  localparam int FB_H = 160;
  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} blit_state_t;
  typedef struct packed {
    logic [9:0] src_stride;
    logic [7:0] spr_w;
    logic [7:0] spr_h;
    logic [9:0] dst_x;
    logic [9:0] dst_y;
    logic       flip_h;
  } blit_req_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
  } blit_tag_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: request, sheet-read and framebuffer-write signals of the blitter.
interface sprite_blitter_if;
  import blit_pkg::*;
  logic          start;
  logic [AW-1:0] src_base;
  logic [9:0]    src_stride;
  logic [7:0]    spr_w;
  logic [7:0]    spr_h;
  logic [9:0]    dst_x;
  logic [9:0]    dst_y;
  logic          flip_h;
  logic          busy;
  logic          done;
  logic [AW-1:0] src_addr;
  logic [23:0]   src_data;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_data;
  modport master (
    output start, src_base, src_stride, spr_w, spr_h, dst_x, dst_y, flip_h, src_data,
    input  busy, done, src_addr, fb_we, fb_addr, fb_data
  );
  modport slave (
    input  start, src_base, src_stride, spr_w, spr_h, dst_x, dst_y, flip_h, src_data,
    output busy, done, src_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/blit_clip_addr.sv
// blit_clip_addr: maps a sprite pixel to its screen position, clip flag and linear framebuffer address.
module blit_clip_addr import blit_pkg::*; (
  input  logic [9:0]    i_dst_x,
  input  logic [9:0]    i_dst_y,
  input  logic [7:0]    i_r,
  input  logic [7:0]    i_c,
  input  logic [7:0]    i_spr_w,
  input  logic          i_flip_h,
  output logic          o_in_bounds,
  output logic [AW-1:0] o_fb_addr
);
  logic [7:0]         w_col;
  logic signed [10:0] w_px;
  logic signed [10:0] w_py;
  always_comb begin
    w_col = i_flip_h ? i_spr_w - 8'd1 - i_c : i_c;
    w_px = $signed({i_dst_x[9], i_dst_x}) + $signed({3'b000, w_col});
    w_py = $signed({i_dst_y[9], i_dst_y}) + $signed({3'b000, i_r});
    o_in_bounds = !w_px[10] && !w_py[10] && w_px[9:0] < 10'(FB_W) && w_py[9:0] < 10'(FB_H);
    // only meaningful when in bounds, where both coordinates fit in 8 bits
    o_fb_addr = AW'(w_py[7:0]) * AW'(FB_W) + AW'(w_px[7:0]);
  end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a sprite from the character sheet into the framebuffer, one pixel per clock,
// with colour-key transparency, horizontal flip and screen-edge clipping.
module sprite_blitter import blit_pkg::*; (
  input logic           Clk,
  input logic           Reset_n,
  sprite_blitter_if.slave bus
);
  blit_state_t   r_state, w_next;
  blit_req_t     r_req;
  blit_tag_t     r_tag, r_ptr, w_cur;
  logic [AW-1:0] r_row, w_row;
  logic [9:0]    w_stride;
  logic [7:0]    w_w;
  logic          r_fb_we;
  logic [AW-1:0] r_fb_addr, w_fb_addr;
  logic [23:0]   r_fb_data;
  logic          w_idle, w_issue, w_wrap, w_last, w_zero, w_one, w_write, w_in_bounds;
  blit_clip_addr u_clip (
    .i_dst_x    (r_req.dst_x),
    .i_dst_y    (r_req.dst_y),
    .i_r        (r_tag.r),
    .i_c        (r_tag.c),
    .i_spr_w    (r_req.spr_w),
    .i_flip_h   (r_req.flip_h),
    .o_in_bounds(w_in_bounds),
    .o_fb_addr  (w_fb_addr)
  );
  // pixel (0,0) is addressed in the start cycle itself so its write lands two edges later
  always_comb begin
    w_idle = r_state == IDLE;
    w_issue = (w_idle && bus.start) || r_state == READ;
    w_cur = w_idle ? '0 : r_ptr;
    w_row = w_idle ? bus.src_base : r_row;
    w_w = w_idle ? bus.spr_w : r_req.spr_w;
    w_stride = w_idle ? bus.src_stride : r_req.src_stride;
    w_wrap = w_cur.c == w_w - 8'd1;
    w_last = w_wrap && r_ptr.r == r_req.spr_h - 8'd1;
    w_zero = bus.spr_w == 8'd0 || bus.spr_h == 8'd0;
    w_one = bus.spr_w == 8'd1 && bus.spr_h == 8'd1;
    w_write = (r_state == READ || r_state == DRAIN) && w_in_bounds && bus.src_data != KEY_COLOR;
    w_next = w_idle ? (bus.start ? (w_zero ? FIN : w_one ? DRAIN : READ) : IDLE)
           : r_state == READ ? (w_last ? DRAIN : READ)
           : r_state == DRAIN ? FIN : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_req <= '0;
      r_tag <= '0;
      r_ptr <= '0;
      r_row <= '0;
      r_fb_we <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_state <= w_next;
      r_fb_we <= w_write;
      if (w_idle && bus.start)
        r_req <= blit_req_t'{src_stride: bus.src_stride, spr_w: bus.spr_w, spr_h: bus.spr_h,
                             dst_x: bus.dst_x, dst_y: bus.dst_y, flip_h: bus.flip_h};
      if (w_issue) begin
        r_tag <= w_cur;
        r_ptr <= w_wrap ? blit_tag_t'{r: w_cur.r + 8'd1, c: 8'd0} : blit_tag_t'{r: w_cur.r, c: w_cur.c + 8'd1};
        r_row <= w_wrap ? w_row + AW'(w_stride) : w_row;
      end
      if (w_write) begin
        r_fb_addr <= w_fb_addr;
        r_fb_data <= bus.src_data;
      end
    end
  end
  assign bus.busy = !w_idle;
  assign bus.done = r_state == FIN;
  assign bus.src_addr = w_issue ? w_row + AW'(w_cur.c) : '0;
  assign bus.fb_we = r_fb_we;
  assign bus.fb_addr = r_fb_addr;
  assign bus.fb_data = r_fb_data;
endmodule
